// File: rtl/disp_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : disp_pkg
//  Description : Shared encodings and defaults for the display scan path.
//  Revision    : 1.0  initial release
// ============================================================================
package disp_pkg;

    // Source shown on the display
    localparam logic [1:0] SRC_OP1 = 2'd0;
    localparam logic [1:0] SRC_OP2 = 2'd1;
    localparam logic [1:0] SRC_RES = 2'd2;

    // Source-select FSM states
    typedef enum logic [0:0] {
        ST_SHOW_OP  = 1'b0,
        ST_SHOW_RES = 1'b1
    } disp_state_t;

    // Default geometry
    localparam int c_def_digits   = 4;
    localparam int c_def_prescale = 4;

endpackage
`default_nettype wire

// File: rtl/disp_tick_gen.sv
`default_nettype none
// ============================================================================
//  Module      : disp_tick_gen
//  Description : Free-running prescaler; tick is high in the last cycle of
//                every PRESCALE-cycle period.
//  Revision    : 1.0  initial release
// ============================================================================
module disp_tick_gen
    import disp_pkg::*;
#(
    parameter int PRESCALE = c_def_prescale
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int                 c_cnt_w = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(PRESCALE - 1);

    logic [c_cnt_w-1:0] r_cnt;

    // Count 0..PRESCALE-1 and wrap
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (r_cnt == c_last) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + c_cnt_w'(1);
        end
    end

    assign tick = (r_cnt == c_last);

endmodule
`default_nettype wire

// File: rtl/disp_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : disp_scan_ctrl
//  Description : Selects operand/result for display, snapshots it at frame
//                start and scans it MSB-first one nibble per slot with
//                leading-zero blanking and a frame sync pulse.
//  Revision    : 1.0  initial release
// ============================================================================
module disp_scan_ctrl
    import disp_pkg::*;
#(
    parameter int DIGITS   = c_def_digits,
    parameter int PRESCALE = c_def_prescale,
    parameter int BLANK_LZ = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [4*DIGITS-1:0]   save1,
    input  logic [4*DIGITS-1:0]   save2,
    input  logic [4*DIGITS-1:0]   result,
    input  logic                  display_state,
    input  logic                  result_valid,
    input  logic                  clear,
    output logic [3:0]            digit_val,
    output logic [DIGITS-1:0]     digit_en,
    output logic                  blank,
    output logic                  sync,
    output logic [1:0]            src
);

    localparam int                 c_w        = 4 * DIGITS;
    localparam int                 c_idx_w    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(DIGITS - 1);

    logic               w_tick;
    logic [c_idx_w-1:0] r_idx;
    logic [c_w-1:0]     r_snap;
    disp_state_t        r_state;
    logic               r_ds_q;

    logic               w_frame_start;
    logic               w_ds_edge;
    logic [c_idx_w-1:0] w_idx_next;
    logic [1:0]         w_src_sel;
    logic [c_w-1:0]     w_src_val;
    logic [c_w-1:0]     w_snap_next;
    logic [3:0]         w_nib;
    logic               w_zero_run;
    logic               w_blank;

    disp_tick_gen #(
        .PRESCALE (PRESCALE)
    ) u_tick (
        .clk   (clk),
        .reset (reset),
        .tick  (w_tick)
    );

    assign w_frame_start = w_tick && (r_idx == c_last_idx);
    assign w_ds_edge     = display_state ^ r_ds_q;
    assign w_idx_next    = (r_idx == c_last_idx) ? '0 : r_idx + c_idx_w'(1);

    // Source currently selected by the FSM
    always_comb begin
        w_src_sel = (r_state == ST_SHOW_RES) ? SRC_RES
                  : (display_state ? SRC_OP2 : SRC_OP1);
        case (w_src_sel)
            SRC_OP2: w_src_val = save2;
            SRC_RES: w_src_val = result;
            default: w_src_val = save1;
        endcase
    end

    // Outputs for the new slot use the snapshot as it stands after this edge,
    // so slot 0 of a new frame already shows the freshly captured value.
    assign w_snap_next = w_frame_start ? w_src_val : r_snap;

    // Nibble for the upcoming slot and whether it lies in a leading-zero run
    always_comb begin
        w_nib      = w_snap_next[c_w-1 - 4*int'(w_idx_next) -: 4];
        w_zero_run = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            if (k <= int'(w_idx_next) && w_snap_next[c_w-1 - 4*k -: 4] != 4'h0) begin
                w_zero_run = 1'b0;
            end
        end
        w_blank = (BLANK_LZ != 0) && (w_idx_next != c_last_idx) && w_zero_run;
    end

    // Source-select FSM; clear has priority, a display_state edge leaves result view
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_SHOW_OP;
            r_ds_q  <= 1'b0;
        end else begin
            r_ds_q <= display_state;
            case (r_state)
                ST_SHOW_OP: begin
                    if (result_valid && !clear) begin
                        r_state <= ST_SHOW_RES;
                    end
                end
                ST_SHOW_RES: begin
                    if (clear || w_ds_edge) begin
                        r_state <= ST_SHOW_OP;
                    end
                end
                default: r_state <= ST_SHOW_OP;
            endcase
        end
    end

    // Slot index, snapshot and registered scan outputs, all advanced on tick
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_idx     <= c_last_idx;
            r_snap    <= '0;
            digit_val <= 4'h0;
            digit_en  <= '0;
            blank     <= 1'b1;
            sync      <= 1'b0;
            src       <= SRC_OP1;
        end else begin
            sync <= 1'b0;
            if (w_tick) begin
                r_idx     <= w_idx_next;
                r_snap    <= w_snap_next;
                digit_val <= w_blank ? 4'h0 : w_nib;
                digit_en  <= DIGITS'(1) << w_idx_next;
                blank     <= w_blank;
                sync      <= w_frame_start;
                if (w_frame_start) begin
                    src <= w_src_sel;
                end
            end
        end
    end

endmodule
`default_nettype wire
